assoc_cache_ctrl: RTL and testbench

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

---
 rtl/assoc_cache_ctrl_pkg.sv | 29 ++
 rtl/cache_way_ram.sv | 56 +++++
 rtl/assoc_cache_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared state encoding and geometry helpers for the 2-way set-associative cache controller.
package assoc_cache_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REFILL = 2'd1;
    localparam state_t ST_WRITE  = 2'd2;
    localparam state_t ST_FLUSH  = 2'd3;

    // Byte-offset bits within a line: 2 for the byte lane plus the word select.
    function automatic int off_w(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int tag_w(input int mem_addr_w, input int index_w, input int words);
        return mem_addr_w - off_w(words) - index_w;
    endfunction

    function automatic int sets(input int index_w);
        return 1 << index_w;
    endfunction

    // Geometry of the default configuration (INDEX_W=6, WORDS=4, MEM_ADDR_W=19).
    localparam int OFF_W = off_w(4);
    localparam int TAG_W = tag_w(19, 6, 4);
    localparam int SETS  = sets(6);

endpackage

// File: rtl/cache_way_ram.sv
// One cache way: line data with per-word write, tag and valid bit per set.
// Reads are combinational; writes land on the clock edge.
module cache_way_ram
    import assoc_cache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int WORDS   = 4,
    parameter int TAG_W   = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INDEX_W-1:0]         idx_i,
    input  logic [$clog2(WORDS)-1:0]   word_i,
    output logic [31:0]                rdata_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       valid_o,
    input  logic                       word_we_i,
    input  logic [$clog2(WORDS)-1:0]   wr_word_i,
    input  logic [31:0]                wdata_i,
    input  logic                       tag_we_i,
    input  logic [TAG_W-1:0]           tag_i,
    input  logic                       inv_i,
    input  logic [INDEX_W-1:0]         inv_idx_i
);

    localparam int N_SETS = sets(INDEX_W);

    logic [31:0]        data_q  [N_SETS][WORDS];
    logic [TAG_W-1:0]   tag_q   [N_SETS];
    logic [N_SETS-1:0]  valid_q;

    always_ff @(posedge clk) begin
        if (word_we_i) begin
            data_q[idx_i][wr_word_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                tag_q[s] <= '0;
            end
        end else if (tag_we_i) begin
            tag_q[idx_i]   <= tag_i;
            valid_q[idx_i] <= 1'b1;
        end else if (inv_i) begin
            valid_q[inv_idx_i] <= 1'b0;
        end
    end

    assign rdata_o = data_q[idx_i][word_i];
    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through/no-allocate cache controller with LRU replacement,
// line refill over a beat-per-sram_ready SRAM port, and a one-set-per-cycle flush.
module assoc_cache_ctrl
    import assoc_cache_ctrl_pkg::*;
#(
    parameter int INDEX_W    = 6,
    parameter int WORDS      = 4,
    parameter int MEM_ADDR_W = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    input  logic        flush,
    output logic        flush_busy,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int WORD_W   = $clog2(WORDS);
    localparam int OFF_BITS = off_w(WORDS);
    localparam int TAG_BITS = tag_w(MEM_ADDR_W, INDEX_W, WORDS);
    localparam int N_SETS   = sets(INDEX_W);

    logic [INDEX_W-1:0]  idx;
    logic [WORD_W-1:0]   word;
    logic [TAG_BITS-1:0] tag;

    assign idx  = address[OFF_BITS +: INDEX_W];
    assign word = address[2 +: WORD_W];
    assign tag  = address[MEM_ADDR_W-1 : OFF_BITS+INDEX_W];

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   beat_q, beat_d;
    logic                victim_q, victim_d;
    logic [INDEX_W-1:0]  flush_idx_q, flush_idx_d;
    logic                flush_pend_q, flush_pend_d;
    logic                refill_done_q, refill_done_d;
    logic [N_SETS-1:0]   lru_q, lru_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [31:0]         way_rdata [2];
    logic [TAG_BITS-1:0] way_tag   [2];
    logic [1:0]          way_valid;
    logic [1:0]          way_word_we, way_tag_we, way_inv;
    logic [WORD_W-1:0]   wr_word;
    logic [31:0]         way_wdata;
    logic [INDEX_W-1:0]  inv_idx;
    logic [1:0]          hit_way;
    logic                hit;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_ram #(
            .INDEX_W (INDEX_W),
            .WORDS   (WORDS),
            .TAG_W   (TAG_BITS)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx_i     (idx),
            .word_i    (word),
            .rdata_o   (way_rdata[w]),
            .tag_o     (way_tag[w]),
            .valid_o   (way_valid[w]),
            .word_we_i (way_word_we[w]),
            .wr_word_i (wr_word),
            .wdata_i   (way_wdata),
            .tag_we_i  (way_tag_we[w]),
            .tag_i     (tag),
            .inv_i     (way_inv[w]),
            .inv_idx_i (inv_idx)
        );
        assign hit_way[w] = way_valid[w] && (way_tag[w] == tag);
    end

    assign hit        = |hit_way;
    assign rdata      = hit_way[1] ? way_rdata[1] : way_rdata[0];
    assign flush_busy = (state_q == ST_FLUSH);
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        victim_d      = victim_q;
        flush_idx_d   = flush_idx_q;
        flush_pend_d  = flush_pend_q | flush;
        refill_done_d = 1'b0;
        lru_d         = lru_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        ready         = 1'b0;
        sram_read     = 1'b0;
        sram_write    = 1'b0;
        sram_address  = '0;
        sram_wdata    = '0;
        way_word_we   = '0;
        way_tag_we    = '0;
        way_inv       = '0;
        wr_word       = word;
        way_wdata     = wdata;
        inv_idx       = idx;

        case (state_q)
            ST_IDLE: begin
                if (mem_w_en) begin
                    state_d = ST_WRITE;
                end else if (mem_r_en) begin
                    if (hit) begin
                        ready        = 1'b1;
                        lru_d[idx]   = hit_way[0];
                        // The completion right after a refill was already counted as a miss.
                        if (!refill_done_q && hit_cnt_q != '1) begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else begin
                        state_d  = ST_REFILL;
                        beat_d   = '0;
                        victim_d = !way_valid[0] ? 1'b0 :
                                   !way_valid[1] ? 1'b1 : lru_q[idx];
                        // Drop the victim now so an interrupted refill never leaves a stale-valid line.
                        way_inv[victim_d] = 1'b1;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_d = miss_cnt_q + 32'd1;
                        end
                    end
                end else if (flush_pend_d) begin
                    state_d      = ST_FLUSH;
                    flush_idx_d  = '0;
                    flush_pend_d = 1'b0;
                end
            end
            ST_REFILL: begin
                sram_read    = 1'b1;
                sram_address = {address[31:OFF_BITS], beat_q, 2'b00};
                wr_word      = beat_q;
                way_wdata    = sram_rdata;
                if (sram_ready) begin
                    way_word_we[victim_q] = 1'b1;
                    if (beat_q == WORD_W'(WORDS - 1)) begin
                        way_tag_we[victim_q] = 1'b1;
                        state_d              = ST_IDLE;
                        refill_done_d        = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                sram_write   = 1'b1;
                sram_address = address;
                sram_wdata   = wdata;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = ST_IDLE;
                    if (hit) begin
                        way_word_we = hit_way;
                        lru_d[idx]  = hit_way[0];
                    end
                end
            end
            ST_FLUSH: begin
                way_inv            = 2'b11;
                inv_idx            = flush_idx_q;
                lru_d[flush_idx_q] = 1'b0;
                if (flush_idx_q == '1) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            victim_q      <= 1'b0;
            flush_idx_q   <= '0;
            flush_pend_q  <= 1'b0;
            refill_done_q <= 1'b0;
            lru_q         <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            victim_q      <= victim_d;
            flush_idx_q   <= flush_idx_d;
            flush_pend_q  <= flush_pend_d;
            refill_done_q <= refill_done_d;
            lru_q         <= lru_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Randomized bench for assoc_cache_ctrl against a true-LRU line-residency model and a backing memory.
module tb_assoc_cache_ctrl;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0, wdata = '0, rdata;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0, ready;
    logic [31:0] sram_address, sram_wdata, sram_rdata = '0;
    logic        sram_read, sram_write, sram_ready = 1'b0;
    logic        flush = 1'b0, flush_busy;
    logic [31:0] hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    int unsigned mem_wr [int unsigned];
    int unsigned mru_line [64];
    int unsigned lru_line [64];
    int          n_valid  [64];
    int unsigned exp_hits = 0, exp_misses = 0;

    assoc_cache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .flush        (flush),
        .flush_busy   (flush_busy),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int unsigned mem_val(input int unsigned a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return (a * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    function automatic bit model_has(input int unsigned a);
        int s = int'((a >> 4) & 63);
        int unsigned ln = a >> 4;
        return (n_valid[s] >= 1 && mru_line[s] == ln) || (n_valid[s] == 2 && lru_line[s] == ln);
    endfunction

    function automatic void model_touch(input int unsigned a);
        int s = int'((a >> 4) & 63);
        int unsigned ln = a >> 4;
        if (n_valid[s] == 2 && lru_line[s] == ln) begin
            lru_line[s] = mru_line[s];
            mru_line[s] = ln;
        end
    endfunction

    function automatic void model_fill(input int unsigned a);
        int s = int'((a >> 4) & 63);
        if (n_valid[s] > 0) lru_line[s] = mru_line[s];
        mru_line[s] = a >> 4;
        if (n_valid[s] < 2) n_valid[s]++;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 64; s++) n_valid[s] = 0;
    endfunction

    task automatic do_read(input logic [31:0] a, input int flush_at, input int abort_at,
                           output int beats_o, output logic [31:0] rdata_o);
        bit exp_hit = model_has(a);
        int beats = 0, cyc = 0, last_beat = -1, ready_cyc = -1;
        bit done = 0, aborted = 0, flushed = 0;
        logic [31:0] base = a & ~32'hF;
        rdata_o = '0;
        address = a;
        mem_r_en = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && beats == abort_at) begin
                aborted = 1;
                break;
            end
            sram_ready = 1'b0;
            checks++;
            if (sram_write !== 1'b0) begin
                errors++;
                $display("FAIL rd_no_write: sram_write=%b required 0 (addr %h)", sram_write, a);
            end
            if (sram_read === 1'b1) begin
                checks++;
                if (sram_address !== base + 32'(4 * beats)) begin
                    errors++;
                    $display("FAIL refill_addr: got %h required %h", sram_address, base + 32'(4 * beats));
                end
                if ($urandom_range(0, 3) != 0) begin
                    sram_ready = 1'b1;
                    sram_rdata = mem_val(sram_address);
                    beats++;
                    last_beat = cyc;
                end
            end
            if (flush_at >= 0 && beats == flush_at && !flushed) begin
                flush = 1'b1;
                flushed = 1;
            end
            #1;
            if (ready === 1'b1) begin
                done = 1;
                ready_cyc = cyc;
                rdata_o = rdata;
            end
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
            flush = 1'b0;
        end
        beats_o = beats;
        if (aborted) return;
        mem_r_en = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rd_timeout: no ready for %h after %0d cycles", a, cyc);
            return;
        end
        checks++;
        if (rdata_o !== mem_val(a)) begin
            errors++;
            $display("FAIL rd_data: addr %h got %h required %h", a, rdata_o, mem_val(a));
        end
        checks++;
        if (beats != (exp_hit ? 0 : WORDS)) begin
            errors++;
            $display("FAIL rd_beats: addr %h got %0d beats required %0d", a, beats, exp_hit ? 0 : WORDS);
        end
        checks++;
        if (ready_cyc != (exp_hit ? 1 : last_beat + 1)) begin
            errors++;
            $display("FAIL rd_latency: addr %h ready at cycle %0d required %0d", a, ready_cyc,
                     exp_hit ? 1 : last_beat + 1);
        end
        if (exp_hit) begin
            model_touch(a);
            exp_hits++;
        end else begin
            model_fill(a);
            exp_misses++;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bit exp_hit = model_has(a);
        int writes = 0, cyc = 0;
        bit done = 0;
        address = a;
        wdata = d;
        mem_w_en = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            sram_ready = 1'b0;
            checks++;
            if (sram_read !== 1'b0) begin
                errors++;
                $display("FAIL wr_no_read: sram_read=%b required 0 (addr %h)", sram_read, a);
            end
            if (sram_write === 1'b1) begin
                checks++;
                if (sram_address !== a || sram_wdata !== d) begin
                    errors++;
                    $display("FAIL wr_bus: got %h/%h required %h/%h", sram_address, sram_wdata, a, d);
                end
                if ($urandom_range(0, 2) != 0) begin
                    sram_ready = 1'b1;
                    writes++;
                end
            end
            #1;
            if (ready === 1'b1) begin
                done = 1;
                checks++;
                if (sram_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_ready_early: ready=1 with sram_ready=%b required 1", sram_ready);
                end
            end
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
        end
        mem_w_en = 1'b0;
        checks++;
        if (!done || writes != 1) begin
            errors++;
            $display("FAIL wr_done: done=%0d writes=%0d required done=1 writes=1", done, writes);
        end
        mem_wr[a] = d;
        if (exp_hit) model_touch(a);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({ready, sram_read, sram_write, flush_busy} !== 4'b0 || hit_cnt !== 0 || miss_cnt !== 0) begin
            errors++;
            $display("FAIL %s: rdy/rd/wr/fb=%b hit=%0d miss=%0d required all 0", tag,
                     {ready, sram_read, sram_write, flush_busy}, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_read();
        int b;
        logic [31:0] d;
        do_read(32'h104, -1, -1, b, d);
        checks++;
        if (d !== mem_val(32'h104) || b != 4) begin
            errors++;
            $display("FAIL cold_read: beats=%0d data=%h required 4/%h", b, d, mem_val(32'h104));
        end
        #1;
        checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cold_counters: miss=%0d hit=%0d required 1/0", miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_eviction();
        int b;
        logic [31:0] d;
        do_read(32'h100, -1, -1, b, d);
        do_read(32'h500, -1, -1, b, d);
        do_read(32'h900, -1, -1, b, d);
        do_read(32'h500, -1, -1, b, d);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL evict_keep_500: got %0d beats required 0", b);
        end
        do_read(32'h100, -1, -1, b, d);
        checks++;
        if (b != 4) begin
            errors++;
            $display("FAIL evict_lost_100: got %0d beats required 4", b);
        end
    endtask

    task automatic test_write_hit();
        int b;
        logic [31:0] d;
        do_write(32'h108, 32'hDEADBEEF);
        do_read(32'h108, -1, -1, b, d);
        checks++;
        if (b != 0 || d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_hit: beats=%0d data=%h required 0/deadbeef", b, d);
        end
    endtask

    task automatic test_write_miss();
        int b;
        logic [31:0] d;
        do_write(32'h2000, $urandom);
        do_read(32'h2000, -1, -1, b, d);
        checks++;
        if (b != 4) begin
            errors++;
            $display("FAIL write_no_alloc: got %0d beats required 4", b);
        end
    endtask

    task automatic test_flush_refill();
        int b, busy = 0, cyc = 0;
        logic [31:0] d;
        bit seen = 0;
        do_read(32'h4440, 1, -1, b, d);
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (flush_busy === 1'b1) begin
                busy++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (busy != 64) begin
            errors++;
            $display("FAIL flush_len: flush_busy high %0d cycles required 64", busy);
        end
        model_clear();
        @(posedge clk);
        #1;
        do_read(32'h100, -1, -1, b, d);
        checks++;
        if (b != 4) begin
            errors++;
            $display("FAIL flush_invalidate: got %0d beats required 4", b);
        end
    endtask

    task automatic test_reset_refill();
        int b;
        logic [31:0] d;
        do_read(32'h3040, -1, 2, b, d);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_refill");
        mem_r_en = 1'b0;
        sram_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        @(posedge clk);
        #1;
        do_read(32'h3040, -1, -1, b, d);
        checks++;
        if (b != 4) begin
            errors++;
            $display("FAIL reset_refill_miss: got %0d beats required 4", b);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) do_read(32'h3040 + 32'(4 * i), -1, -1, b, d);
    endtask

    task automatic test_random();
        int b;
        logic [31:0] d;
        int sel [3] = '{3, 16, 40};
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a = (32'($urandom_range(0, 3)) << 10) | (32'(sel[$urandom_range(0, 2)]) << 4)
                             | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 3) == 0) do_write(a, $urandom);
            else do_read(a, -1, -1, b, d);
        end
        #1;
        checks++;
        if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin
            errors++;
            $display("FAIL counters: hit=%0d miss=%0d required %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_read();
        test_eviction();
        test_write_hit();
        test_write_miss();
        test_flush_refill();
        test_reset_refill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
